mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- Parameterised-width 4-to-1 data multiplexer with a 2-bit select.
- Provides a combinational output and a registered copy of the selected word, for use in datapath steering (e.g. register-file or ALU operand selection).
- The registered path gives downstream logic a timing-clean, resettable version of the output.

Parameters:
- WIDTH, 8, bit width of each data input and of both data outputs; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a0  input  WIDTH  data input selected when s = 2'b00.
- a1  input  WIDTH  data input selected when s = 2'b01.
- a2  input  WIDTH  data input selected when s = 2'b10.
- a3  input  WIDTH  data input selected when s = 2'b11.
- s  input  2  select.
- en  input  1  load enable for the output register.
- q  output  WIDTH  combinational selected data.
- q_reg  output  WIDTH  registered selected data.
- s_reg  output  2  select value captured with q_reg.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk, reset port is rst_n.

Behaviour:
- Combinational path, zero latency:
  - q = a0 when s=00, a1 when s=01, a2 when s=10, a3 when s=11.
  - q follows any change on s or on the selected input within the same delta cycle.
  - q does not depend on clk, rst_n or en; q stays valid during reset.
- Unknown select: if s contains X or Z, q drives all-zero. This is a synthesizable default branch; no latch is inferred.
- Registered path:
  - On a rising clk edge with rst_n=1 and en=1: q_reg <= the current q and s_reg <= s.
  - One-cycle latency from s or data to q_reg.
  - With en=0, q_reg and s_reg hold their values.
- Reset:
  - rst_n=0 asynchronously forces q_reg = 0 and s_reg = 2'b00, independent of clk.
  - Both outputs stay at those values while rst_n=0.
  - Deassertion of rst_n is taken synchronously by the design around the block. The first load occurs on the first rising edge with rst_n=1 and en=1.
  - Reset asserted mid-operation clears q_reg and s_reg immediately; q is unaffected.
- Simultaneous events: s and data changing in the same cycle as a clock edge are treated as a single consistent sample. Setup and hold are met by the surrounding design.
- Width rules:
  - All data paths are exactly WIDTH bits.
  - No extension or truncation.
  - Inputs are passed through bit-exact.

Decomposition:
- Shared package mux_pkg holds the select encodings SEL_A0=2'b00, SEL_A1=2'b01, SEL_A2=2'b10, SEL_A3=2'b11.
- One natural sub-module, mux_4to1_core: the pure combinational WIDTH-bit 4:1 selector producing q.
- mux_4to1 instantiates mux_4to1_core and adds the enable register stage for q_reg and s_reg.

Test Plan:
- Select sweep, WIDTH=8, a0=8'h00, a1=8'h11, a2=8'h22, a3=8'h33, en=0:
  - s=00 -> q=8'h00.
  - After 200 ns, s=01 -> q=8'h11.
  - After a further 200 ns, s=10 -> q=8'h22.
  - After a further 200 ns, s=11 -> q=8'h33.
  - Each result appears with zero delay after s changes.
- Registered latency, same data, en=1, s stepped 00,01,10,11 on consecutive cycles:
  - q_reg reads 00,11,22,33 one cycle after each step.
  - s_reg tracks s one cycle late.
- Enable hold, s=10 loaded with en=1 (q_reg=8'h22), then en=0 and s=11:
  - q=8'h33 immediately.
  - q_reg stays 8'h22 and s_reg stays 2'b10 for 5 cycles.
- Async reset with q_reg=8'h33:
  - Drive rst_n=0 between clock edges -> q_reg=8'h00 and s_reg=00 at once; q still 8'h33.
  - Release rst_n=1 with en=1 -> q_reg=8'h33 after the next edge.
- Data-follow: s=01, en=0, change a1 from 8'h11 to 8'hA5 -> q=8'hA5 in the same delta cycle; q_reg unchanged.
- X select: s=2'bx1 -> q=8'h00 (all-zero).

Source files
------------

// File: rtl/mux_pkg.sv
// Select encodings shared by the 4:1 multiplexer and its combinational core.
package mux_pkg;

    localparam logic [1:0] SEL_A0 = 2'b00;
    localparam logic [1:0] SEL_A1 = 2'b01;
    localparam logic [1:0] SEL_A2 = 2'b10;
    localparam logic [1:0] SEL_A3 = 2'b11;

endpackage

// File: rtl/mux_4to1_core.sv
// Pure combinational WIDTH-bit 4:1 selector; zero latency.
// No flow control: output follows select and data continuously.
module mux_4to1_core
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] q
);

    // An unresolvable select falls into default and drives zero, never a latch.
    always_comb begin
        q = '0;
        case (s)
            SEL_A0:  q = a0;
            SEL_A1:  q = a1;
            SEL_A2:  q = a2;
            SEL_A3:  q = a3;
            default: q = '0;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 multiplexer with combinational output q and an enable-loaded copy q_reg/s_reg.
// q has zero latency; q_reg/s_reg lag by one cycle. No backpressure: en=0 simply holds.
module mux_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_reg,
    output logic [1:0]       s_reg
);

    mux_4to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a0 (a0),
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .s  (s),
        .q  (q)
    );

    // The captured select travels with the word so consumers know its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            s_reg <= SEL_A0;
        end else if (en) begin
            q_reg <= q;
            s_reg <= s;
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: directed vectors, literal checks, and a per-cycle reference model compare.
module tb_mux_4to1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a0, a1, a2, a3;
    logic [1:0]       s;
    logic             en;
    logic [WIDTH-1:0] q, q_reg;
    logic [1:0]       s_reg;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    logic [WIDTH-1:0] m_qreg = '0;
    logic [1:0]       m_sreg = 2'b00;

    mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .s     (s),
        .en    (en),
        .q     (q),
        .q_reg (q_reg),
        .s_reg (s_reg)
    );

    always #5 clk = ~clk;

    // Reference selection: index the four inputs as a table; unknown select yields zero.
    function automatic logic [WIDTH-1:0] ref_sel(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] d0, d1, d2, d3);
        logic [WIDTH-1:0] tbl [4];
        tbl = '{d0, d1, d2, d3};
        if ($isunknown(sel)) return '0;
        return tbl[sel];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered model: the last word selected at an enabled edge, zero while reset is held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_qreg <= '0;
            m_sreg <= 2'b00;
        end else if (en) begin
            m_qreg <= ref_sel(s, a0, a1, a2, a3);
            m_sreg <= s;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_q", {56'd0, q}, {56'd0, ref_sel(s, a0, a1, a2, a3)});
            check("model_q_reg", {56'd0, q_reg}, {56'd0, m_qreg});
            check("model_s_reg", {62'd0, s_reg}, {62'd0, m_sreg});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] exp_tbl [4];
        exp_tbl = '{8'h00, 8'h11, 8'h22, 8'h33};

        rst_n = 1'b1;
        a0 = 8'h00; a1 = 8'h11; a2 = 8'h22; a3 = 8'h33;
        s = 2'b00; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_q_reg", {56'd0, q_reg}, 64'h00);
        check("reset_s_reg", {62'd0, s_reg}, 64'h0);
        check("reset_q_valid", {56'd0, q}, 64'h00);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;

        // Select sweep with en=0
        s = 2'b00; #1 check("sweep_s00", {56'd0, q}, 64'h00);
        #200 s = 2'b01; #1 check("sweep_s01", {56'd0, q}, 64'h11);
        #200 s = 2'b10; #1 check("sweep_s10", {56'd0, q}, 64'h22);
        #200 s = 2'b11; #1 check("sweep_s11", {56'd0, q}, 64'h33);
        check("sweep_q_reg_idle", {56'd0, q_reg}, 64'h00);

        // Registered latency, s stepped on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            en = 1'b1;
            s  = 2'(i);
            @(posedge clk); #1;
            check("lat_q_reg", {56'd0, q_reg}, {56'd0, exp_tbl[i]});
            check("lat_s_reg", {62'd0, s_reg}, 64'(i));
        end

        // Enable hold
        @(negedge clk); #1 s = 2'b10;
        @(posedge clk); #1 check("hold_load", {56'd0, q_reg}, 64'h22);
        @(negedge clk); #1 en = 1'b0; s = 2'b11;
        #1 check("hold_q_now", {56'd0, q}, 64'h33);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_q_reg", {56'd0, q_reg}, 64'h22);
            check("hold_s_reg", {62'd0, s_reg}, 64'h2);
        end

        // Async reset mid-operation
        @(negedge clk); #1 en = 1'b1;
        @(posedge clk); #1 check("pre_rst_q_reg", {56'd0, q_reg}, 64'h33);
        @(negedge clk); #3 rst_n = 1'b0;
        #1;
        check("arst_q_reg", {56'd0, q_reg}, 64'h00);
        check("arst_s_reg", {62'd0, s_reg}, 64'h0);
        check("arst_q", {56'd0, q}, 64'h33);
        @(posedge clk); #1 check("arst_held", {56'd0, q_reg}, 64'h00);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_q_reg", {56'd0, q_reg}, 64'h33);
        check("rel_s_reg", {62'd0, s_reg}, 64'h3);

        // Data-follow on the selected input
        @(negedge clk); #1 en = 1'b0; s = 2'b01;
        #1 check("follow_before", {56'd0, q}, 64'h11);
        a1 = 8'hA5;
        #1 check("follow_after", {56'd0, q}, 64'hA5);
        check("follow_q_reg", {56'd0, q_reg}, 64'h33);
        @(posedge clk); #1 check("follow_q_reg_edge", {56'd0, q_reg}, 64'h33);

        // Unknown select: only meaningful where the simulator keeps X
        @(negedge clk); #1 s = 2'bx1;
        #1 if ($isunknown(s)) check("xsel_q", {56'd0, q}, 64'h00);
        @(negedge clk); #1 s = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
